echo_delay_line_sequencer: RTL

//  Owns the single-port delay-line RAM behind the echo effect.

---
 rtl/echo_delay_line_sequencer_pkg.sv | 21 ++
 rtl/echo_delay_line_sequencer_if.sv | 52 +++++
 rtl/echo_delay_line_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/echo_delay_line_sequencer_pkg.sv
// Shared definitions for the echo delay-line sequencer.
//   audio_width_default : sample width shared with the encoder/decoder
//   state_t             : sequencer states (clear / idle / read / write)
//   delay_addr_width()  : RAM address width for a given delay in stereo frames
package echo_delay_line_sequencer_pkg;

    localparam int audio_width_default = 16;

    typedef enum logic [1:0] {
        state_clear = 2'd0,
        state_idle  = 2'd1,
        state_read  = 2'd2,
        state_write = 2'd3
    } state_t;

    // Two words (left/right) per stereo frame.
    function automatic int delay_addr_width(input int delay_samples);
        return $clog2(2 * delay_samples);
    endfunction

endpackage

// File: rtl/echo_delay_line_sequencer_if.sv
// Bus interfaces around the echo delay-line sequencer.
//   echo_delay_line_sequencer_if : sample request/response channel
//     master = echo datapath (requester), slave = sequencer
//     req_valid/req_ready handshake, req_is_left, req_audio,
//     rsp_valid (1-cycle pulse, no backpressure), rsp_audio
//   echo_delay_line_ram_if : single-port synchronous RAM port
//     master = sequencer, slave = RAM
//     ram_addr, ram_we, ram_wdata, ram_rdata (1-cycle read latency)
interface echo_delay_line_sequencer_if
    import echo_delay_line_sequencer_pkg::*;
#(
    parameter int audio_width = audio_width_default
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_is_left;
    logic [audio_width-1:0] req_audio;
    logic                   rsp_valid;
    logic [audio_width-1:0] rsp_audio;

    modport master (
        output req_valid, req_is_left, req_audio,
        input  req_ready, rsp_valid, rsp_audio
    );

    modport slave (
        input  req_valid, req_is_left, req_audio,
        output req_ready, rsp_valid, rsp_audio
    );
endinterface

interface echo_delay_line_ram_if
    import echo_delay_line_sequencer_pkg::*;
#(
    parameter int audio_width = audio_width_default,
    parameter int addr_width  = 12
);
    logic [addr_width-1:0]  ram_addr;
    logic                   ram_we;
    logic [audio_width-1:0] ram_wdata;
    logic [audio_width-1:0] ram_rdata;

    modport master (
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/echo_delay_line_sequencer.sv
// Echo delay-line sequencer: owns the external single-port delay RAM.
// Zero-fills the RAM after reset or clear_req, then serves one
// read-then-write transaction per accepted sample: the slot
// {frame_ptr, ~is_left} is read (returning the sample stored delay_samples
// frames earlier) and then overwritten with the new sample.
// Ports:
//   clk, reset   : bit clock, asynchronous active-high reset
//   clear_req    : restart the zero-fill from address 0 (wins over requests)
//   busy         : high while zero-filling
//   req          : request/response channel (slave side)
//   ram          : RAM port (master side)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// state_clear | writing zero to clr_addr, one word per clock
// state_idle  | req_ready high, waiting for a sample request
// state_read  | slot address on the RAM, read data arrives next edge
// state_write | return read data, write the new sample into the same slot
module echo_delay_line_sequencer
    import echo_delay_line_sequencer_pkg::*;
#(
    parameter int audio_width   = audio_width_default,
    parameter int delay_samples = 2048
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_req,
    output logic                         busy,
    echo_delay_line_sequencer_if.slave   req,
    echo_delay_line_ram_if.master        ram
);

    localparam int addr_width = delay_addr_width(delay_samples);
    localparam int ptr_width  = addr_width - 1;
    localparam logic [addr_width-1:0] last_addr = addr_width'(2 * delay_samples - 1);

    state_t                 state, state_d;
    logic [addr_width-1:0]  clr_addr, clr_addr_d;
    logic [ptr_width-1:0]   frame_ptr, frame_ptr_d;
    logic                   lat_is_left, lat_is_left_d;
    logic [audio_width-1:0] lat_audio, lat_audio_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [audio_width-1:0] rsp_audio_q, rsp_audio_d;
    logic [addr_width-1:0]  ram_addr_q, ram_addr_d;
    logic                   ram_we_q, ram_we_d;
    logic [audio_width-1:0] ram_wdata_q, ram_wdata_d;
    logic                   accept;

    // clear_req masks the handshake in the same cycle so a request is never
    // accepted into a transaction that the clear would abandon.
    assign req.req_ready = ready_q & ~clear_req;
    assign accept        = req.req_valid & req.req_ready;

    assign busy          = busy_q;
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_audio = rsp_audio_q;
    assign ram.ram_addr  = ram_addr_q;
    assign ram.ram_we    = ram_we_q;
    assign ram.ram_wdata = ram_wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= state_clear;
            clr_addr    <= '0;
            frame_ptr   <= '0;
            lat_is_left <= 1'b0;
            lat_audio   <= '0;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_audio_q <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            state       <= state_d;
            clr_addr    <= clr_addr_d;
            frame_ptr   <= frame_ptr_d;
            lat_is_left <= lat_is_left_d;
            lat_audio   <= lat_audio_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_audio_q <= rsp_audio_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    always_comb begin
        state_d       = state;
        clr_addr_d    = clr_addr;
        frame_ptr_d   = frame_ptr;
        lat_is_left_d = lat_is_left;
        lat_audio_d   = lat_audio;
        busy_d        = busy_q;
        ready_d       = ready_q;
        rsp_valid_d   = 1'b0;
        rsp_audio_d   = rsp_audio_q;
        ram_addr_d    = ram_addr_q;
        ram_we_d      = 1'b0;
        ram_wdata_d   = ram_wdata_q;

        if (clear_req) begin
            state_d     = state_clear;
            clr_addr_d  = '0;
            frame_ptr_d = '0;
            busy_d      = 1'b1;
            ready_d     = 1'b0;
            ram_addr_d  = '0;
            ram_wdata_d = '0;
        end else begin
            unique case (state)
                state_clear: begin
                    busy_d      = 1'b1;
                    ready_d     = 1'b0;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = '0;
                    ram_addr_d  = clr_addr;
                    clr_addr_d  = clr_addr + addr_width'(1);
                    if (clr_addr == last_addr) begin
                        state_d = state_idle;
                    end
                end
                state_idle: begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    if (accept) begin
                        ready_d       = 1'b0;
                        ram_addr_d    = {frame_ptr, ~req.req_is_left};
                        lat_is_left_d = req.req_is_left;
                        lat_audio_d   = req.req_audio;
                        state_d       = state_read;
                    end
                end
                state_read: begin
                    state_d = state_write;
                end
                state_write: begin
                    // Read data for the slot is on ram_rdata now; the write of
                    // the new sample lands on the following edge, so the
                    // returned word is always the old contents.
                    rsp_valid_d = 1'b1;
                    rsp_audio_d = ram.ram_rdata;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = lat_audio;
                    ready_d     = 1'b1;
                    if (!lat_is_left) begin
                        frame_ptr_d = frame_ptr + ptr_width'(1);
                    end
                    state_d = state_idle;
                end
                default: begin
                    state_d = state_clear;
                end
            endcase
        end
    end

endmodule
